zeroheti_dbg_obi_arb: RTL and testbench

ZEROHETI_DBG_OBI_ARB -- requirements
Module: zeroheti_dbg_obi_arb

---
 rtl/zeroheti_dbg_obi_arb_pkg.sv | 15 +
 rtl/zeroheti_dbg_obi_arb_if.sv | 27 ++
 rtl/zeroheti_id_fifo.sv | 55 +++++
 rtl/zeroheti_dbg_obi_arb.sv | 114 +++++++++++
 tb/tb_zeroheti_dbg_obi_arb.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/zeroheti_dbg_obi_arb_pkg.sv
// Shared types for the core/debug OBI arbiter: requester IDs and default depth.
package zeroheti_pkg;

  typedef enum logic {
    ReqCore = 1'b0,
    ReqDbg  = 1'b1
  } req_id_e;

  localparam int unsigned MaxOutstandingDefault = 2;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == ReqCore) ? ReqDbg : ReqCore;
  endfunction

endpackage

// File: rtl/zeroheti_dbg_obi_arb_if.sv
// OBI request/response bundle; master drives the address phase, slave answers.
interface zeroheti_dbg_obi_arb_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();

  logic                   req;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   wdata;
  logic                   gnt;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic                   err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/zeroheti_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
module zeroheti_id_fifo
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth = MaxOutstandingDefault
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  logic    pop_i,
  input  req_id_e id_i,
  output logic    full_o,
  output logic    empty_o,
  output req_id_e head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  req_id_e         mem_q [Depth];
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= ReqCore;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= id_i;
        wptr_q        <= next_ptr(wptr_q);
      end
      if (do_pop) rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/zeroheti_dbg_obi_arb.sv
// Two-requester OBI arbiter (core, debug) onto one manager port with in-order response steering.
// Define ZEROHETI_DBG_ARB_FIXPRIO_EN for fixed debug priority instead of round-robin.
module zeroheti_dbg_obi_arb
  import zeroheti_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  zeroheti_dbg_obi_arb_if.slave  core,
  zeroheti_dbg_obi_arb_if.slave  dbg,
  zeroheti_dbg_obi_arb_if.master mgr
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [0:0]             state_q, state_d;
  req_id_e                win_q, winner;
  logic                   win_req, mgr_req, hs, rsp_valid;
  logic                   fifo_full, fifo_empty;
  req_id_e                fifo_head;
  logic [AddrWidth-1:0]   addr_mux;
  logic [DataWidth/8-1:0] be_mux;
  logic [DataWidth-1:0]   wdata_mux;
  logic                   we_mux;

`ifndef ZEROHETI_DBG_ARB_FIXPRIO_EN
  req_id_e prio_q;
`endif

  // HOLD keeps the stalled winner so the address phase stays stable until granted.
  always_comb begin
    winner = ReqCore;
    if (state_q == StHold) begin
      winner = win_q;
    end else if (core.req && dbg.req) begin
`ifdef ZEROHETI_DBG_ARB_FIXPRIO_EN
      winner = ReqDbg;
`else
      winner = prio_q;
`endif
    end else if (dbg.req) begin
      winner = ReqDbg;
    end
  end

  assign win_req   = (winner == ReqDbg) ? dbg.req   : core.req;
  assign addr_mux  = (winner == ReqDbg) ? dbg.addr  : core.addr;
  assign we_mux    = (winner == ReqDbg) ? dbg.we    : core.we;
  assign be_mux    = (winner == ReqDbg) ? dbg.be    : core.be;
  assign wdata_mux = (winner == ReqDbg) ? dbg.wdata : core.wdata;

  assign mgr_req   = win_req && !fifo_full;
  assign hs        = mgr_req && mgr.gnt;
  assign rsp_valid = mgr.rvalid && !fifo_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (mgr_req && !mgr.gnt) state_d = StHold;
      StHold:  if (mgr.gnt) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      win_q   <= ReqCore;
`ifndef ZEROHETI_DBG_ARB_FIXPRIO_EN
      prio_q  <= ReqDbg;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= winner;
`ifndef ZEROHETI_DBG_ARB_FIXPRIO_EN
      if (hs) prio_q <= other_req(winner);
`endif
    end
  end

  zeroheti_id_fifo #(
    .Depth(MaxOutstanding)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .pop_i  (rsp_valid),
    .id_i   (winner),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  // Outputs are gated by rst_ni so reset forces them low without waiting for a clock.
  assign mgr.req     = rst_ni && mgr_req;
  assign mgr.addr    = rst_ni ? addr_mux  : '0;
  assign mgr.we      = rst_ni && we_mux;
  assign mgr.be      = rst_ni ? be_mux    : '0;
  assign mgr.wdata   = rst_ni ? wdata_mux : '0;

  assign core.gnt    = rst_ni && hs && (winner == ReqCore);
  assign dbg.gnt     = rst_ni && hs && (winner == ReqDbg);
  assign core.rvalid = rst_ni && rsp_valid && (fifo_head == ReqCore);
  assign dbg.rvalid  = rst_ni && rsp_valid && (fifo_head == ReqDbg);
  assign core.rdata  = rst_ni ? mgr.rdata : '0;
  assign dbg.rdata   = rst_ni ? mgr.rdata : '0;
  assign core.err    = rst_ni && mgr.err;
  assign dbg.err     = rst_ni && mgr.err;

endmodule

// File: tb/tb_zeroheti_dbg_obi_arb.sv
// Directed self-checking bench for zeroheti_dbg_obi_arb (MaxOutstanding = 2).
module tb_zeroheti_dbg_obi_arb;

`ifdef ZEROHETI_DBG_ARB_FIXPRIO_EN
  localparam bit FixPrio = 1'b1;
`else
  localparam bit FixPrio = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  zeroheti_dbg_obi_arb_if #(.AddrWidth(32), .DataWidth(32)) core_if ();
  zeroheti_dbg_obi_arb_if #(.AddrWidth(32), .DataWidth(32)) dbg_if ();
  zeroheti_dbg_obi_arb_if #(.AddrWidth(32), .DataWidth(32)) mgr_if ();

  zeroheti_dbg_obi_arb #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .MaxOutstanding(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .core  (core_if),
    .dbg   (dbg_if),
    .mgr   (mgr_if)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic creq, input logic dreq, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic err);
    core_if.req   = creq;
    dbg_if.req    = dreq;
    mgr_if.gnt    = gnt;
    mgr_if.rvalid = rv;
    mgr_if.rdata  = rdata;
    mgr_if.err    = err;
    #2;
  endtask

  initial begin
    core_if.req = 0; core_if.addr = 32'h1000; core_if.we = 0; core_if.be = 4'hF; core_if.wdata = 32'hC0C0;
    dbg_if.req  = 0; dbg_if.addr  = 32'h2000; dbg_if.we  = 1; dbg_if.be  = 4'h3; dbg_if.wdata  = 32'hD0D0;
    mgr_if.gnt = 0; mgr_if.rvalid = 0; mgr_if.rdata = '0; mgr_if.err = 0;

    // Reset state: outputs forced low even with live inputs.
    #1;
    drive(1, 1, 1, 1, 32'hFFFF_FFFF, 1);
    chk("rst_mgr_req", mgr_if.req, 0);
    chk("rst_core_gnt", core_if.gnt, 0);
    chk("rst_dbg_rvalid", dbg_if.rvalid, 0);
    chk("rst_mgr_addr", mgr_if.addr, 0);
    chk("rst_core_rdata", core_if.rdata, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // First contention after reset: dbg wins, zero-cycle grant.
    drive(1, 1, 1, 0, 0, 0);
    chk("c1_dbg_gnt", dbg_if.gnt, 1);
    chk("c1_core_gnt", core_if.gnt, 0);
    chk("c1_mgr_addr", mgr_if.addr, 32'h2000);
    chk("c1_mgr_we", mgr_if.we, 1);
    chk("c1_mgr_be", mgr_if.be, 4'h3);
    tick();
    // Second contention: core in round-robin, dbg again with fixed priority.
    drive(1, 1, 1, 0, 0, 0);
    chk("c2_core_gnt", core_if.gnt, FixPrio ? 0 : 1);
    chk("c2_dbg_gnt", dbg_if.gnt, FixPrio ? 1 : 0);
    chk("c2_mgr_addr", mgr_if.addr, FixPrio ? 32'h2000 : 32'h1000);
    tick();
    // FIFO full: no request, no grant.
    drive(1, 1, 1, 0, 0, 0);
    chk("full_mgr_req", mgr_if.req, 0);
    chk("full_core_gnt", core_if.gnt, 0);
    chk("full_dbg_gnt", dbg_if.gnt, 0);
    // Responses return in grant order; data/err reach both requesters.
    drive(0, 0, 0, 1, 32'h11, 1);
    chk("r1_dbg_rvalid", dbg_if.rvalid, 1);
    chk("r1_core_rvalid", core_if.rvalid, 0);
    chk("r1_dbg_rdata", dbg_if.rdata, 32'h11);
    chk("r1_core_err", core_if.err, 1);
    tick();
    drive(0, 0, 0, 1, 32'h22, 0);
    chk("r2_core_rvalid", core_if.rvalid, FixPrio ? 0 : 1);
    chk("r2_dbg_rvalid", dbg_if.rvalid, FixPrio ? 1 : 0);
    chk("r2_core_rdata", core_if.rdata, 32'h22);
    tick();
    // Stray response with empty FIFO is dropped.
    drive(0, 0, 0, 1, 32'h33, 0);
    chk("stray_core_rvalid", core_if.rvalid, 0);
    chk("stray_dbg_rvalid", dbg_if.rvalid, 0);
    tick();

    // Stalled core request holds address while dbg arrives.
    core_if.addr = 32'h3000; dbg_if.addr = 32'h4000;
    drive(1, 0, 0, 0, 0, 0);
    chk("h0_mgr_req", mgr_if.req, 1);
    chk("h0_mgr_addr", mgr_if.addr, 32'h3000);
    tick();
    for (int c = 1; c <= 2; c++) begin
      drive(1, 1, 0, 0, 0, 0);
      chk("hold_mgr_addr", mgr_if.addr, 32'h3000);
      chk("hold_dbg_gnt", dbg_if.gnt, 0);
      tick();
    end
    drive(1, 1, 1, 0, 0, 0);
    chk("h3_core_gnt", core_if.gnt, 1);
    chk("h3_dbg_gnt", dbg_if.gnt, 0);
    chk("h3_mgr_addr", mgr_if.addr, 32'h3000);
    tick();
    // Core just handshook, so dbg takes the next contention in both builds.
    drive(1, 1, 1, 0, 0, 0);
    chk("h4_dbg_gnt", dbg_if.gnt, 1);
    chk("h4_mgr_addr", mgr_if.addr, 32'h4000);
    tick();

    // Full (core, dbg): response pops but gives no same-cycle bypass.
    drive(1, 0, 1, 1, 32'hA5A5_A5A5, 0);
    chk("nb_mgr_req", mgr_if.req, 0);
    chk("nb_core_gnt", core_if.gnt, 0);
    chk("nb_core_rvalid", core_if.rvalid, 1);
    chk("nb_core_rdata", core_if.rdata, 32'hA5A5_A5A5);
    chk("nb_core_err", core_if.err, 0);
    tick();
    // Count 1: push core and pop dbg together.
    drive(1, 0, 1, 1, 32'h5A5A_5A5A, 1);
    chk("pp_mgr_req", mgr_if.req, 1);
    chk("pp_core_gnt", core_if.gnt, 1);
    chk("pp_dbg_rvalid", dbg_if.rvalid, 1);
    chk("pp_core_rvalid", core_if.rvalid, 0);
    chk("pp_dbg_rdata", dbg_if.rdata, 32'h5A5A_5A5A);
    chk("pp_dbg_err", dbg_if.err, 1);
    tick();
    // Count still 1: exactly one more grant fits.
    drive(1, 0, 1, 0, 0, 0);
    chk("c1_more_gnt", core_if.gnt, 1);
    tick();
    drive(1, 0, 1, 0, 0, 0);
    chk("c2_full_req", mgr_if.req, 0);

    // Reset with two outstanding core IDs.
    drive(1, 1, 1, 1, 32'h77, 1);
    chk("pre_rst_core_rvalid", core_if.rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_core_rvalid", core_if.rvalid, 0);
    chk("arst_core_gnt", core_if.gnt, 0);
    chk("arst_dbg_gnt", dbg_if.gnt, 0);
    chk("arst_mgr_req", mgr_if.req, 0);
    chk("arst_core_rdata", core_if.rdata, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 32'h88, 0);
    chk("post_rst_core_rvalid", core_if.rvalid, 0);
    chk("post_rst_dbg_rvalid", dbg_if.rvalid, 0);
    tick();
    drive(1, 1, 1, 0, 0, 0);
    chk("post_rst_dbg_gnt", dbg_if.gnt, 1);
    chk("post_rst_core_gnt", core_if.gnt, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
